// File: rtl/weight_stream_loader_if.sv
// rtl/weight_stream_loader_if.sv - weight-store read port and weight-load beat bus
// master = loader side, slave = store/main_net side.
interface weight_stream_loader_if #(
  parameter int DATA_WIDTH           = 32,
  parameter int LAYER_WIDTH          = 2,
  parameter int WEIGHT_COUNTER_WIDTH = 11
);
  logic                            o_mem_rd_en;
  logic [WEIGHT_COUNTER_WIDTH-1:0] o_mem_rd_addr;
  logic [DATA_WIDTH-1:0]           i_mem_rd_data;
  logic                            o_weight_valid;
  logic [LAYER_WIDTH-1:0]          o_weight_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr;
  logic [DATA_WIDTH-1:0]           o_weight;

  modport master (
    output o_mem_rd_en, o_mem_rd_addr,
    input  i_mem_rd_data,
    output o_weight_valid, o_weight_layer, o_weight_addr, o_weight
  );

  modport slave (
    input  o_mem_rd_en, o_mem_rd_addr,
    output i_mem_rd_data,
    input  o_weight_valid, o_weight_layer, o_weight_addr, o_weight
  );
endinterface

// File: rtl/weight_stream_loader.sv
// rtl/weight_stream_loader.sv - streams a flat weight store into main_net, layer by layer
// Reads hidden-1, hidden-2, output weights with a one-cycle gap between layers, then pulses done.
module weight_stream_loader #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int WEIGHT_COUNTER_WIDTH          = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_load_done,
  weight_stream_loader_if.master bus
);
  localparam int CW    = WEIGHT_COUNTER_WIDTH;
  localparam int L1    = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int L2    = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int L3    = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
  localparam int TOTAL = L1 + L2 + L3;

  localparam logic [CW-1:0] L1_LAST = CW'(L1 - 1);
  localparam logic [CW-1:0] L2_LAST = CW'(L2 - 1);
  localparam logic [CW-1:0] L3_LAST = CW'(L3 - 1);
  localparam logic [CW-1:0] BASE2   = CW'(L1);
  localparam logic [CW-1:0] BASE3   = CW'(L1 + L2);

  localparam logic [LAYER_WIDTH-1:0] LAYER_NONE = '0;
  localparam logic [LAYER_WIDTH-1:0] LAYER_H1   = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] LAYER_H2   = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] LAYER_OUT  = LAYER_WIDTH'(3);

  generate
    if (TOTAL > (1 << CW)) begin : g_size_check
      $error("weight store of %0d words does not fit a %0d-bit address", TOTAL, CW);
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, RD_L1, GAP1, RD_L2, GAP2, RD_L3, DRAIN, DONE} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_rd_en;
  logic [CW-1:0]           r_rd_addr;
  logic [LAYER_WIDTH-1:0]  r_rd_layer;
  logic                    r_busy;
  logic                    r_done;

  logic                    r_s1_valid;
  logic [LAYER_WIDTH-1:0]  r_s1_layer;
  logic [CW-1:0]           r_s1_addr;
  logic                    r_valid;
  logic [LAYER_WIDTH-1:0]  r_layer;
  logic [CW-1:0]           r_addr;
  logic [DATA_WIDTH-1:0]   r_data;

  // Read-side FSM; r_rd_* describe the read issued in the current cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_layer <= LAYER_NONE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // r_done still high here means this is the done cycle: start is ignored.
          if (i_start && !r_done) begin
            r_state    <= RD_L1;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= '0;
            r_rd_layer <= LAYER_H1;
          end
        end
        RD_L1: begin
          if (r_cnt == L1_LAST) begin
            r_state    <= GAP1;
            r_cnt      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_layer <= LAYER_NONE;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        GAP1: begin
          r_state    <= RD_L2;
          r_rd_en    <= 1'b1;
          r_rd_addr  <= BASE2;
          r_rd_layer <= LAYER_H2;
        end
        RD_L2: begin
          if (r_cnt == L2_LAST) begin
            r_state    <= GAP2;
            r_cnt      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_layer <= LAYER_NONE;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        GAP2: begin
          r_state    <= RD_L3;
          r_rd_en    <= 1'b1;
          r_rd_addr  <= BASE3;
          r_rd_layer <= LAYER_OUT;
        end
        RD_L3: begin
          if (r_cnt == L3_LAST) begin
            r_state    <= DRAIN;
            r_cnt      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_layer <= LAYER_NONE;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        DRAIN: r_state <= DONE;
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and address ride two stages so they line up with the registered store data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_layer <= LAYER_NONE;
      r_s1_addr  <= '0;
      r_valid    <= 1'b0;
      r_layer    <= LAYER_NONE;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_s1_valid <= r_rd_en;
      r_s1_layer <= r_rd_layer;
      r_s1_addr  <= r_cnt;
      r_valid    <= r_s1_valid;
      r_layer    <= r_s1_valid ? r_s1_layer : LAYER_NONE;
      r_addr     <= r_s1_valid ? r_s1_addr : '0;
      r_data     <= r_s1_valid ? bus.i_mem_rd_data : '0;
    end
  end

  assign bus.o_mem_rd_en    = r_rd_en;
  assign bus.o_mem_rd_addr  = r_rd_addr;
  assign bus.o_weight_valid = r_valid;
  assign bus.o_weight_layer = r_layer;
  assign bus.o_weight_addr  = r_addr;
  assign bus.o_weight       = r_data;
  assign o_busy             = r_busy;
  assign o_load_done        = r_done;
endmodule

// File: tb/tb_weight_stream_loader.sv
// tb/tb_weight_stream_loader.sv - randomized self-checking bench for weight_stream_loader
module tb_weight_stream_loader;
  localparam int DW   = 32;
  localparam int LW   = 2;
  localparam int CW   = 11;
  localparam int MAXK = 1400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] mem [0:2047];

  weight_stream_loader_if #(.DATA_WIDTH(DW), .LAYER_WIDTH(LW), .WEIGHT_COUNTER_WIDTH(CW)) bus_b();
  weight_stream_loader_if #(.DATA_WIDTH(DW), .LAYER_WIDTH(LW), .WEIGHT_COUNTER_WIDTH(CW)) bus_s();

  logic busy_b, done_b, busy_s, done_s;
  wire  start_b = start & ~sel;
  wire  start_s = start & sel;

  weight_stream_loader dut_b (
    .clk(clk), .rst(rst), .i_start(start_b),
    .o_busy(busy_b), .o_load_done(done_b), .bus(bus_b)
  );

  weight_stream_loader #(
    .NUMBER_OF_HIDDEN_NODE_LAYER_1(4),
    .NUMBER_OF_HIDDEN_NODE_LAYER_2(4)
  ) dut_s (
    .clk(clk), .rst(rst), .i_start(start_s),
    .o_busy(busy_s), .o_load_done(done_s), .bus(bus_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_b.o_mem_rd_en) bus_b.i_mem_rd_data <= mem[bus_b.o_mem_rd_addr];
    if (bus_s.o_mem_rd_en) bus_s.i_mem_rd_data <= mem[bus_s.o_mem_rd_addr];
  end

  wire          obs_rd     = sel ? bus_s.o_mem_rd_en    : bus_b.o_mem_rd_en;
  wire [CW-1:0] obs_rdaddr = sel ? bus_s.o_mem_rd_addr  : bus_b.o_mem_rd_addr;
  wire          obs_valid  = sel ? bus_s.o_weight_valid : bus_b.o_weight_valid;
  wire [LW-1:0] obs_layer  = sel ? bus_s.o_weight_layer : bus_b.o_weight_layer;
  wire [CW-1:0] obs_addr   = sel ? bus_s.o_weight_addr  : bus_b.o_weight_addr;
  wire [DW-1:0] obs_data   = sel ? bus_s.o_weight       : bus_b.o_weight;
  wire          obs_busy   = sel ? busy_s : busy_b;
  wire          obs_done   = sel ? done_s : done_b;

  bit            exp_v      [0:MAXK];
  logic [LW-1:0] exp_layer  [0:MAXK];
  logic [CW-1:0] exp_addr   [0:MAXK];
  logic [DW-1:0] exp_data   [0:MAXK];
  bit            exp_rd     [0:MAXK];
  logic [CW-1:0] exp_rdaddr [0:MAXK];

  task automatic fill_mem();
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
  endtask

  // Expected timeline per cycle k after the start edge: beat stream from the layer layout.
  task automatic run_load(input int in_n, input int h1, input int h2, input int out_n,
                          input int repulse_k, input int extra, input string name);
    int len [3];
    int base [3];
    int off, total, done_off, bad, beats, dones, done_k, first_v, first_rd;
    string first_bad;
    for (int k = 0; k <= MAXK; k++) begin
      exp_v[k] = 0; exp_rd[k] = 0; exp_layer[k] = '0;
      exp_addr[k] = '0; exp_data[k] = '0; exp_rdaddr[k] = '0;
    end
    len[0] = h1 * (in_n + 1);
    len[1] = h2 * (h1 + 1);
    len[2] = out_n * (h2 + 1);
    base[0] = 0;
    base[1] = len[0];
    base[2] = len[0] + len[1];
    total = len[0] + len[1] + len[2];
    off = 3;
    for (int l = 0; l < 3; l++) begin
      for (int a = 0; a < len[l]; a++) begin
        exp_v[off]        = 1;
        exp_layer[off]    = LW'(l + 1);
        exp_addr[off]     = CW'(a);
        exp_data[off]     = mem[base[l] + a];
        exp_rd[off-2]     = 1;
        exp_rdaddr[off-2] = CW'(base[l] + a);
        off++;
      end
      if (l < 2) off++;
    end
    done_off = off;
    bad = 0; beats = 0; dones = 0; done_k = 0; first_v = 0; first_rd = 0; first_bad = "";

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= done_off + extra; k++) begin
      bit   ok;
      logic exp_busy;
      exp_busy = (k < done_off);
      ok = (obs_valid === exp_v[k]) && (obs_layer === exp_layer[k]) && (obs_rd === exp_rd[k])
           && (obs_busy === exp_busy) && (obs_done === (k == done_off));
      if (exp_v[k])  ok = ok && (obs_addr === exp_addr[k]) && (obs_data === exp_data[k]);
      if (exp_rd[k]) ok = ok && (obs_rdaddr === exp_rdaddr[k]);
      if (!ok) begin
        if (bad == 0)
          first_bad = $sformatf("k=%0d got v=%b l=%0d a=%0d d=%h rd=%b ra=%0d busy=%b done=%b want v=%b l=%0d a=%0d d=%h rd=%b ra=%0d busy=%b done=%b",
                                k, obs_valid, obs_layer, obs_addr, obs_data, obs_rd, obs_rdaddr, obs_busy, obs_done,
                                exp_v[k], exp_layer[k], exp_addr[k], exp_data[k], exp_rd[k], exp_rdaddr[k], exp_busy, k == done_off);
        bad++;
      end
      if (obs_valid) beats++;
      if (obs_valid && first_v == 0) first_v = k;
      if (obs_rd && first_rd == 0) first_rd = k;
      if (obs_done) begin dones++; done_k = k; end
      start = (repulse_k > 0) && (k == repulse_k || k == done_off);
      if (k < done_off + extra) @(negedge clk);
    end
    start = 1'b0;

    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s stream: %0d bad cycles, first %s", name, bad, first_bad); end
    checks++;
    if (beats !== total) begin errors++; $display("FAIL %s beats: got %0d want %0d", name, beats, total); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, dones); end
    checks++;
    if (done_k !== done_off) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_k, done_off); end
    checks++;
    if (first_v !== 3) begin errors++; $display("FAIL %s first_valid_cycle: got %0d want 3", name, first_v); end
    checks++;
    if (first_rd !== 1) begin errors++; $display("FAIL %s first_rd_cycle: got %0d want 1", name, first_rd); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus_b.o_weight_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", bus_b.o_weight_valid); end
    checks++;
    if (bus_b.o_weight_layer !== 2'b00) begin errors++; $display("FAIL reset layer: got %b want 00", bus_b.o_weight_layer); end
    checks++;
    if (bus_b.o_mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset rd_en: got %b want 0", bus_b.o_mem_rd_en); end
    checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL reset busy_done: got %b%b want 00", busy_b, done_b); end
    checks++;
    if (bus_b.o_weight !== '0 || bus_b.o_weight_addr !== '0) begin errors++; $display("FAIL reset data_addr: got %h/%0d want 0/0", bus_b.o_weight, bus_b.o_weight_addr); end
    checks++;
    if (bus_s.o_weight_valid !== 1'b0 || busy_s !== 1'b0) begin errors++; $display("FAIL reset small: got valid=%b busy=%b want 0 0", bus_s.o_weight_valid, busy_s); end
    rst = 1'b0;
  endtask

  task automatic test_full_stream();
    sel = 1'b0; fill_mem();
    run_load(2, 32, 32, 3, 0, 0, "full");
  endtask

  task automatic test_start_while_busy();
    sel = 1'b0; fill_mem();
    run_load(2, 32, 32, 3, 503, 10, "restart_ignored");
  endtask

  task automatic test_reset_mid_load();
    bit hit;
    int dones;
    sel = 1'b0; fill_mem();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      if (obs_valid && obs_layer == 2'd2 && obs_addr == 11'd300) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midreset reach_l2_a300: got timeout want beat seen"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_layer !== 2'b00) begin errors++; $display("FAIL midreset async_out: got valid=%b layer=%b want 0 00", obs_valid, obs_layer); end
    checks++;
    if (obs_busy !== 1'b0 || obs_rd !== 1'b0) begin errors++; $display("FAIL midreset async_busy: got busy=%b rd=%b want 0 0", obs_busy, obs_rd); end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (obs_done || obs_valid) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midreset idle_after: got %0d active cycles want 0", dones); end
    run_load(2, 32, 32, 3, 0, 0, "after_reset");
  endtask

  task automatic test_small_params();
    sel = 1'b1; fill_mem();
    run_load(2, 4, 4, 3, 0, 0, "small");
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; fill_mem();
    run_load(2, 32, 32, 3, 0, 0, "b2b_first");
    run_load(2, 32, 32, 3, 0, 0, "b2b_second");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_mem();
    repeat (3) @(negedge clk);
    test_reset();
    test_full_stream();
    test_start_while_busy();
    test_reset_mid_load();
    test_small_params();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
